// File: rtl/adc_clk_gen.sv
// adc_clk_gen: burst ADC clock generator with ADC reset pulse sequencing.
// Build option ADC_CLK_SKEW_EN adds a per-channel 0-3 cycle output skew.
module adc_clk_gen #(
    parameter int N_CH    = 2,
    parameter int DIV_W   = 8,
    parameter int CNT_W   = 16,
    parameter int RST_LEN = 4
) (
    input  logic             clk_200MHz_i,
    input  logic             reset,
    input  logic             clock_to_ADC_req,
    input  logic             stop_i,
    input  logic [DIV_W-1:0] div_i,
    input  logic [CNT_W-1:0] burst_len_i,
    input  logic [N_CH-1:0]  ch_en_i,
`ifdef ADC_CLK_SKEW_EN
    input  logic [2*N_CH-1:0] skew_i,
`endif
    output logic [N_CH-1:0]  clk_adc_o,
    output logic             reset_ADC_signal,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] edge_cnt_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RST  = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_STOP = 2'd3;

    localparam int RW = (RST_LEN > 1) ? $clog2(RST_LEN) : 1;
    localparam logic [RW-1:0] RST_LAST = RW'(RST_LEN - 1);

    logic [1:0]       r_state;
    logic [DIV_W-1:0] r_div;
    logic [CNT_W-1:0] r_burst;
    logic [N_CH-1:0]  r_ch_en;
    logic [CNT_W-1:0] r_cnt;
    logic [RW-1:0]    r_rstc;
    logic [DIV_W-1:0] r_ph;
    logic             r_mclk;
    logic             r_rst_adc;
    logic             r_done;
    logic [N_CH-1:0]  r_clk;

    logic [1:0]       w_state_nxt;
    logic [DIV_W-1:0] w_div_nxt;
    logic [CNT_W-1:0] w_burst_nxt;
    logic [N_CH-1:0]  w_ch_en_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [RW-1:0]    w_rstc_nxt;
    logic [DIV_W-1:0] w_ph_nxt;
    logic             w_mclk_nxt;
    logic             w_rst_adc_nxt;
    logic             w_done_nxt;
    logic             w_latch;

    logic [DIV_W-1:0] w_div_eff;
    logic             w_ph_end;
    logic             w_last;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [N_CH-1:0]  w_gate;
    logic [N_CH-1:0]  w_clk_nxt;

    assign w_div_eff = (r_div == '0) ? DIV_W'(1) : r_div;
    assign w_ph_end  = (r_ph == (w_div_eff - DIV_W'(1)));
    assign w_last    = (r_burst != '0) && (r_cnt == r_burst);
    assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);

    always_comb begin
        w_state_nxt   = r_state;
        w_div_nxt     = r_div;
        w_burst_nxt   = r_burst;
        w_ch_en_nxt   = r_ch_en;
        w_cnt_nxt     = r_cnt;
        w_rstc_nxt    = r_rstc;
        w_ph_nxt      = r_ph;
        w_mclk_nxt    = r_mclk;
        w_rst_adc_nxt = r_rst_adc;
        w_done_nxt    = 1'b0;
        w_latch       = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_mclk_nxt = 1'b0;
                if (clock_to_ADC_req) begin
                    w_latch       = 1'b1;
                    w_div_nxt     = div_i;
                    w_burst_nxt   = burst_len_i;
                    w_ch_en_nxt   = ch_en_i;
                    w_cnt_nxt     = '0;
                    w_rstc_nxt    = '0;
                    w_ph_nxt      = '0;
                    w_rst_adc_nxt = 1'b1;
                    w_state_nxt   = ST_RST;
                end
            end
            ST_RST: begin
                if (stop_i) begin
                    w_rst_adc_nxt = 1'b0;
                    w_done_nxt    = 1'b1;
                    w_state_nxt   = ST_IDLE;
                end else if (r_rstc == RST_LAST) begin
                    w_rst_adc_nxt = 1'b0;
                    w_ph_nxt      = '0;
                    w_state_nxt   = ST_RUN;
                end else begin
                    w_rstc_nxt = r_rstc + RW'(1);
                end
            end
            ST_RUN: begin
                if (!w_ph_end) begin
                    w_ph_nxt = r_ph + DIV_W'(1);
                    if (stop_i)
                        w_state_nxt = ST_STOP;
                end else if (r_mclk) begin
                    // a final falling edge wins over a coincident stop
                    w_ph_nxt   = '0;
                    w_mclk_nxt = 1'b0;
                    if (w_last) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else if (stop_i) begin
                        w_state_nxt = ST_STOP;
                    end
                end else if (stop_i) begin
                    w_state_nxt = ST_STOP;
                end else begin
                    w_ph_nxt   = '0;
                    w_mclk_nxt = 1'b1;
                    w_cnt_nxt  = w_cnt_inc;
                end
            end
            ST_STOP: begin
                if (!r_mclk || w_ph_end) begin
                    w_ph_nxt    = '0;
                    w_mclk_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_ph_nxt = r_ph + DIV_W'(1);
                end
            end
            default: begin
                w_mclk_nxt  = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_gate = {N_CH{w_mclk_nxt}} & w_ch_en_nxt;

    always_ff @(posedge clk_200MHz_i or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_div     <= '0;
            r_burst   <= '0;
            r_ch_en   <= '0;
            r_cnt     <= '0;
            r_rstc    <= '0;
            r_ph      <= '0;
            r_mclk    <= 1'b0;
            r_rst_adc <= 1'b0;
            r_done    <= 1'b0;
            r_clk     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_div     <= w_div_nxt;
            r_burst   <= w_burst_nxt;
            r_ch_en   <= w_ch_en_nxt;
            r_cnt     <= w_cnt_nxt;
            r_rstc    <= w_rstc_nxt;
            r_ph      <= w_ph_nxt;
            r_mclk    <= w_mclk_nxt;
            r_rst_adc <= w_rst_adc_nxt;
            r_done    <= w_done_nxt;
            r_clk     <= w_clk_nxt;
        end
    end

`ifdef ADC_CLK_SKEW_EN
    logic [2*N_CH-1:0]     r_skew;
    logic [N_CH-1:0][2:0]  r_sh;

    always_comb begin
        w_clk_nxt = '0;
        for (int k = 0; k < N_CH; k++) begin
            unique case (r_skew[2*k +: 2])
                2'd0:    w_clk_nxt[k] = w_gate[k];
                2'd1:    w_clk_nxt[k] = r_sh[k][0];
                2'd2:    w_clk_nxt[k] = r_sh[k][1];
                default: w_clk_nxt[k] = r_sh[k][2];
            endcase
        end
    end

    // delay line keeps draining zeros after the master stops
    always_ff @(posedge clk_200MHz_i or negedge reset) begin
        if (!reset) begin
            r_skew <= '0;
            r_sh   <= '0;
        end else begin
            if (w_latch)
                r_skew <= skew_i;
            for (int k = 0; k < N_CH; k++)
                r_sh[k] <= {r_sh[k][1:0], w_gate[k]};
        end
    end
`else
    assign w_clk_nxt = w_gate;
`endif

    assign clk_adc_o        = r_clk;
    assign reset_ADC_signal = r_rst_adc;
    assign busy_o           = (r_state != ST_IDLE);
    assign done_o           = r_done;
    assign edge_cnt_o       = r_cnt;

endmodule

// File: tb/tb_adc_clk_gen.sv
// tb_adc_clk_gen: directed bursts with hand-computed expectations.
// Skew build only ties skew_i to zero delay.
module tb_adc_clk_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        stop = 1'b0;
    logic [7:0]  div = '0;
    logic [15:0] burst = '0;
    logic [1:0]  ch = '0;
    logic [1:0]  clk_adc;
    logic        rst_sig;
    logic        busy;
    logic        done;
    logic [15:0] edge_cnt;
`ifdef ADC_CLK_SKEW_EN
    logic [3:0]  skew = '0;
`endif

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    adc_clk_gen dut (
        .clk_200MHz_i    (clk),
        .reset           (rst_n),
        .clock_to_ADC_req(req),
        .stop_i          (stop),
        .div_i           (div),
        .burst_len_i     (burst),
        .ch_en_i         (ch),
`ifdef ADC_CLK_SKEW_EN
        .skew_i          (skew),
`endif
        .clk_adc_o       (clk_adc),
        .reset_ADC_signal(rst_sig),
        .busy_o          (busy),
        .done_o          (done),
        .edge_cnt_o      (edge_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // sample i is taken just after the edge that samples the iteration-i inputs
    task automatic run_seq(
        input string tag, input int n,
        input logic [7:0] d, input logic [15:0] b, input logic [1:0] c,
        input int stop_at, input int req_hold,
        input int e_rst, input int e_r0, input int e_r1, input int e_hi0,
        input int e_first, input int e_didx, input int e_edge);
        int rst_hi = 0;
        int r0 = 0;
        int r1 = 0;
        int hi0 = 0;
        int first = -1;
        int dn = 0;
        int didx = -1;
        int hi_at_done = 0;
        logic [1:0] prev = 2'b00;
        for (int i = 0; i < n; i++) begin
            req  = (i < req_hold);
            stop = (i == stop_at);
            if (i == 0) begin
                div = d; burst = b; ch = c;
            end else begin
                div = 8'd7; burst = 16'd1; ch = ~c;
            end
            tick();
            if (rst_sig) rst_hi++;
            if (clk_adc[0] && !prev[0]) r0++;
            if (clk_adc[1] && !prev[1]) r1++;
            if (clk_adc[0]) hi0++;
            if (first < 0 && clk_adc != 2'b00) first = i;
            if (done) begin
                dn++;
                if (didx < 0) didx = i;
                if (clk_adc != 2'b00) hi_at_done = 1;
            end
            prev = clk_adc;
        end
        req = 1'b0;
        stop = 1'b0;
        chk({tag, ".rst_len"}, rst_hi, e_rst);
        chk({tag, ".rise0"}, r0, e_r0);
        chk({tag, ".rise1"}, r1, e_r1);
        chk({tag, ".hi0"}, hi0, e_hi0);
        chk({tag, ".first_hi"}, first, e_first);
        chk({tag, ".done_n"}, dn, 1);
        chk({tag, ".done_idx"}, didx, e_didx);
        chk({tag, ".clk_at_done"}, hi_at_done, 0);
        chk({tag, ".edge_cnt"}, edge_cnt, e_edge);
        chk({tag, ".busy_end"}, busy, 0);
        chk({tag, ".clk_end"}, clk_adc, 0);
    endtask

    initial begin
        #3;
        chk("rst.clk", clk_adc, 0);
        chk("rst.rsig", rst_sig, 0);
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        chk("rst.edge", edge_cnt, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        run_seq("b3d2", 24, 8'd2, 16'd3, 2'b11, -1, 1,
                4, 3, 3, 6, 6, 16, 3);
        run_seq("d0b5", 24, 8'd0, 16'd5, 2'b01, -1, 1,
                4, 5, 0, 5, 5, 14, 5);
        run_seq("startwins", 24, 8'd2, 16'd3, 2'b11, 0, 1,
                4, 3, 3, 6, 6, 16, 3);
        run_seq("reqhold", 24, 8'd2, 16'd3, 2'b11, -1, 10,
                4, 3, 3, 6, 6, 16, 3);
        run_seq("stopfinal", 24, 8'd2, 16'd3, 2'b11, 16, 1,
                4, 3, 3, 6, 6, 16, 3);
        run_seq("contstop", 70, 8'd3, 16'd0, 2'b11, 62, 1,
                4, 10, 10, 30, 7, 64, 10);
        run_seq("rststop", 10, 8'd2, 16'd3, 2'b11, 2, 1,
                2, 0, 0, 0, -1, 2, 0);
        run_seq("afterstop", 24, 8'd2, 16'd3, 2'b11, -1, 1,
                4, 3, 3, 6, 6, 16, 3);

        div = 8'd2; burst = 16'd3; ch = 2'b11;
        req = 1'b1;
        tick();
        req = 1'b0;
        repeat (7) tick();
        chk("midrst.pre_clk", clk_adc, 3);
        chk("midrst.pre_edge", edge_cnt, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst.clk", clk_adc, 0);
        chk("midrst.busy", busy, 0);
        chk("midrst.edge", edge_cnt, 0);
        chk("midrst.rsig", rst_sig, 0);
        tick();
        chk("midrst.done", done, 0);
        rst_n = 1'b1;
        tick();
        chk("midrst.done2", done, 0);
        run_seq("afterrst", 24, 8'd2, 16'd3, 2'b10, -1, 1,
                4, 0, 3, 0, 6, 16, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/adc_clk_gen.md
ADC_CLK_GEN -- requirements
Module: adc_clk_gen

Interface
REQ-001 SHALL have parameter N_CH, default 2: number of ADC clock output channels.
REQ-002 SHALL have parameter DIV_W, default 8: width of half-period divider.
REQ-003 SHALL have parameter CNT_W, default 16: width of burst length and edge counter.
REQ-004 SHALL have parameter RST_LEN, default 4: ADC reset pulse length in clock cycles, at least 1.
REQ-005 SHALL have port clk_200MHz_i  in  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port clock_to_ADC_req  in  1  start request, sampled only in IDLE.
REQ-008 SHALL have port stop_i  in  1  abort or stop request.
REQ-009 SHALL have port div_i  in  DIV_W  ADC clock half-period in clk cycles; 0 treated as 1.
REQ-010 SHALL have port burst_len_i  in  CNT_W  number of ADC rising edges; 0 = continuous.
REQ-011 SHALL have port ch_en_i  in  N_CH  per-channel output enable.
REQ-012 SHALL have port clk_adc_o  out  N_CH  registered ADC clocks.
REQ-013 SHALL have port reset_ADC_signal  out  1  active-high ADC reset pulse.
REQ-014 SHALL have port busy_o  out  1  high in any state other than IDLE.
REQ-015 SHALL have port done_o  out  1  one-cycle end-of-operation pulse.
REQ-016 SHALL have port edge_cnt_o  out  CNT_W  rising edges issued in the current or last burst.

Function
REQ-017 SHALL implement FSM states IDLE, RST_ADC, RUN, STOP.
REQ-018 IDLE: on clock_to_ADC_req=1, SHALL latch div_i, burst_len_i and ch_en_i, clear edge_cnt_o, and enter RST_ADC on the next edge.
REQ-019 RST_ADC: reset_ADC_signal SHALL be high for exactly RST_LEN cycles, then the FSM SHALL enter RUN.
REQ-020 RUN: the master ADC clock SHALL start low and toggle every max(div,1) cycles, with its first rising edge max(div,1) cycles after RUN entry.
REQ-021 Each master rising edge SHALL increment edge_cnt_o, saturating at all-ones.
REQ-022 clk_adc_o[k] SHALL equal the master clock when latched ch_en[k]=1, else constant 0.
REQ-023 With burst_len nonzero, after the falling edge that follows rising edge number burst_len, the FSM SHALL enter IDLE and pulse done_o.
REQ-024 stop_i=1 in RUN SHALL enter STOP; STOP SHALL complete the current high phase, if any, then enter IDLE with clocks low and pulse done_o.
REQ-025 stop_i=1 in RST_ADC SHALL deassert reset_ADC_signal on the next cycle, enter IDLE and pulse done_o.
REQ-026 clock_to_ADC_req outside IDLE SHALL be ignored.
REQ-027 Input changes during a burst SHALL have no effect until the next start.
REQ-028 If stop_i and clock_to_ADC_req are both high in IDLE, start SHALL win and stop SHALL be ignored.
REQ-029 A stop on the same cycle as the final falling edge SHALL produce a single done_o pulse.
REQ-030 Every clk_adc_o bit SHALL be a flop output and SHALL never glitch.

Reset
REQ-031 With reset low, SHALL force state IDLE, clk_adc_o=0, reset_ADC_signal=0, busy_o=0, done_o=0, edge_cnt_o=0, and clear all counters and latched inputs.
REQ-032 Reset asserted mid-burst SHALL drive clocks low immediately (asynchronously), without a done_o pulse.

Configuration
REQ-033 With macro ADC_CLK_SKEW_EN defined, SHALL add input skew_i (2*N_CH bits), latched at start, delaying clk_adc_o[k] by skew_i[2k+1:2k] cycles (0-3) through a per-channel shift register.
REQ-034 Under ADC_CLK_SKEW_EN, done_o SHALL follow the master clock; skewed outputs may fall up to 3 cycles after done_o and SHALL be 0 by done+3.
REQ-035 Without ADC_CLK_SKEW_EN, skew_i SHALL be absent and every channel SHALL have zero delay.

Verification
REQ-036 Start, div=2, burst=3, ch_en=2'b11, RST_LEN=4 -> reset_ADC_signal high 4 cycles; 3 clock periods of 4 cycles on both outputs; done_o 1 cycle; edge_cnt_o=3.
REQ-037 div=0, burst=5, ch_en=2'b01 -> ch0 toggles every cycle with 5 rising edges; ch1 stays 0.
REQ-038 burst=0, div=3; stop_i at edge 10 while the clock is high -> high phase completes, clocks low, done_o, edge_cnt_o=10.
REQ-039 stop_i during RST_ADC -> reset_ADC_signal drops next cycle; no ADC clock edge; done_o pulse; a new request is then accepted.
REQ-040 reset driven low mid-burst -> all outputs 0 asynchronously; a request after release runs normally.
REQ-041 ADC_CLK_SKEW_EN, skew_i=4'b1100 -> ch1 equals ch0 delayed by 3 cycles, with the same edge count on both.
